// File: rtl/dmi_responder_pkg.sv
// -----------------------------------------------------------------------------
// dm package: shared DMI payload types, op encodings, response codes,
// debug-module register addresses and the responder FSM state type.
// Imported by dmi_responder and dmi_resp_regfile.
// -----------------------------------------------------------------------------
package dm;

    localparam int unsigned DmiAddrW = 7;
    localparam int unsigned DmiDataW = 32;
    localparam int unsigned DmiOpW   = 2;
    localparam int unsigned DmiRespW = 2;

    // DMI request payload
    typedef struct packed {
        logic [DmiAddrW-1:0] addr;
        logic [DmiOpW-1:0]   op;
        logic [DmiDataW-1:0] data;
    } dmi_req_t;

    // DMI response payload
    typedef struct packed {
        logic [DmiDataW-1:0] data;
        logic [DmiRespW-1:0] resp;
    } dmi_resp_t;

    // Op encodings; the remaining code (3) is handled like a nop
    localparam logic [DmiOpW-1:0] DTM_NOP   = 2'h0;
    localparam logic [DmiOpW-1:0] DTM_READ  = 2'h1;
    localparam logic [DmiOpW-1:0] DTM_WRITE = 2'h2;

    // Response codes
    localparam logic [DmiRespW-1:0] DTM_SUCCESS = 2'h0;
    localparam logic [DmiRespW-1:0] DTM_FAILED  = 2'h2;
    localparam logic [DmiRespW-1:0] DTM_BUSY    = 2'h3;

    // Register address map
    localparam logic [DmiAddrW-1:0] ADDR_DATA0     = 7'h04;
    localparam logic [DmiAddrW-1:0] ADDR_DMCONTROL = 7'h10;
    localparam logic [DmiAddrW-1:0] ADDR_DMSTATUS  = 7'h11;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmi_state_e;

endpackage : dm

// File: rtl/dmi_resp_regfile.sv
// -----------------------------------------------------------------------------
// dmi_resp_regfile: debug-module register storage and address decode.
//   clk, rst    : clock, synchronous active-high reset (clears all storage)
//   we          : commit strobe for a write access
//   wr_op       : current access is a write (used for error decode)
//   addr, wdata : access address and write data
//   rdata_c     : read data for addr (0 when unmapped)
//   hit_c       : addr is a mapped register
//   err_c       : access would fail (unmapped, or write to dmstatus)
//   dmactive    : dmcontrol bit 0
//   haltreq     : dmcontrol bit 31
// -----------------------------------------------------------------------------
module dmi_resp_regfile
    import dm::*;
#(
    parameter int unsigned NrDataRegs  = 4,
    parameter logic [31:0] DmstatusVal = 32'h0000_0082
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic                wr_op,
    input  logic [DmiAddrW-1:0] addr,
    input  logic [DmiDataW-1:0] wdata,
    output logic [DmiDataW-1:0] rdata_c,
    output logic                hit_c,
    output logic                err_c,
    output logic                dmactive,
    output logic                haltreq
);

    logic [DmiDataW-1:0] data_q [NrDataRegs];
    logic                dmactive_q;
    logic                haltreq_q;

    // Read decode
    always_comb begin
        rdata_c = '0;
        hit_c   = 1'b0;
        for (int i = 0; i < int'(NrDataRegs); i++) begin
            if (addr == DmiAddrW'(32'(ADDR_DATA0) + i)) begin
                hit_c   = 1'b1;
                rdata_c = data_q[i];
            end
        end
        if (addr == ADDR_DMCONTROL) begin
            hit_c   = 1'b1;
            rdata_c = {haltreq_q, 30'd0, dmactive_q};
        end
        if (addr == ADDR_DMSTATUS) begin
            hit_c   = 1'b1;
            rdata_c = DmstatusVal;
        end
        err_c = !hit_c || (wr_op && (addr == ADDR_DMSTATUS));
    end

    // Storage; writes to dmstatus or unmapped addresses simply match nothing
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NrDataRegs); i++) begin
                data_q[i] <= '0;
            end
            dmactive_q <= 1'b0;
            haltreq_q  <= 1'b0;
        end else if (we) begin
            for (int i = 0; i < int'(NrDataRegs); i++) begin
                if (addr == DmiAddrW'(32'(ADDR_DATA0) + i)) begin
                    data_q[i] <= wdata;
                end
            end
            if (addr == ADDR_DMCONTROL) begin
                dmactive_q <= wdata[0];
                haltreq_q  <= wdata[31];
            end
        end
    end

    assign dmactive = dmactive_q;
    assign haltreq  = haltreq_q;

endmodule : dmi_resp_regfile

// File: rtl/dmi_responder.sv
// -----------------------------------------------------------------------------
// dmi_responder: DMI request/response handshake and access FSM in front of the
// debug-module register file.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   dmi_clear_i        : flush any in-flight transaction
//   dmi_req_i / dmi_req_valid_i / dmi_req_ready_o    : request channel
//   dmi_resp_o / dmi_resp_valid_o / dmi_resp_ready_i : response channel
//   dmactive_o, haltreq_o : dmcontrol bit 0 / bit 31
// Optional feature macro: DMI_RESP_ERR_EN -- when defined, unmapped accesses,
// writes to dmstatus and op=3 respond with the failed code.
// -----------------------------------------------------------------------------
module dmi_responder
    import dm::*;
#(
    parameter int unsigned NrDataRegs  = 4,
    parameter logic [31:0] DmstatusVal = 32'h0000_0082
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      dmi_clear_i,
    input  dmi_req_t  dmi_req_i,
    input  logic      dmi_req_valid_i,
    output logic      dmi_req_ready_o,
    output dmi_resp_t dmi_resp_o,
    output logic      dmi_resp_valid_o,
    input  logic      dmi_resp_ready_i,
    output logic      dmactive_o,
    output logic      haltreq_o
);

`ifdef DMI_RESP_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    dmi_state_e state_q, state_d;
    dmi_req_t   req_q, req_d;
    dmi_resp_t  resp_q, resp_d;
    logic       resp_valid_q, resp_valid_d;
    logic       req_ready_q, req_ready_d;
    logic       regs_we_c;

    logic [DmiDataW-1:0] rdata_c;
    logic                hit_c;
    logic                err_c;

    dmi_resp_regfile #(
        .NrDataRegs  (NrDataRegs),
        .DmstatusVal (DmstatusVal)
    ) u_regfile (
        .clk      (clk_i),
        .rst      (rst_i),
        .we       (regs_we_c),
        .wr_op    (req_q.op == DTM_WRITE),
        .addr     (req_q.addr),
        .wdata    (req_q.data),
        .rdata_c  (rdata_c),
        .hit_c    (hit_c),
        .err_c    (err_c),
        .dmactive (dmactive_o),
        .haltreq  (haltreq_o)
    );

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            req_q        <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // Next-state, access decode and response formation
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        resp_d    = resp_q;
        regs_we_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dmi_req_valid_i && !dmi_clear_i) begin
                    req_d   = dmi_req_i;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                resp_d = '0;
                case (req_q.op)
                    DTM_READ: begin
                        resp_d.data = rdata_c;
                        resp_d.resp = (ErrEn && !hit_c) ? DTM_FAILED : DTM_SUCCESS;
                    end
                    DTM_WRITE: begin
                        regs_we_c   = 1'b1;
                        resp_d.resp = (ErrEn && err_c) ? DTM_FAILED : DTM_SUCCESS;
                    end
                    DTM_NOP: begin
                        resp_d.resp = DTM_SUCCESS;
                    end
                    default: begin
                        resp_d.resp = ErrEn ? DTM_FAILED : DTM_SUCCESS;
                    end
                endcase
                state_d = RESP;
            end
            RESP: begin
                if (dmi_resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush: abandon the transaction, suppress any pending commit
        if (dmi_clear_i) begin
            state_d   = IDLE;
            resp_d    = '0;
            regs_we_c = 1'b0;
        end

        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

    // Ready is additionally masked while a flush is requested
    assign dmi_req_ready_o  = req_ready_q && !dmi_clear_i;
    assign dmi_resp_o       = resp_q;
    assign dmi_resp_valid_o = resp_valid_q;

endmodule : dmi_responder
